// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the SRAM arbiter.
// Holds the FSM encoding, SRAM bus widths and the starve-counter width helper.
// No logic lives here.
package sram_arbiter_pkg;

  localparam int SRAM_AW = 19;
  localparam int SRAM_DW = 16;
  // Timer width covers ACCESS_CYCLES up to 15.
  localparam int TIMER_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WR_PULSE = 3'd3,
    ST_WR_HOLD  = 3'd4,
    ST_TURN     = 3'd5
  } state_t;

  // Width needed to count 0..max_losses inclusive.
  function automatic int starve_cnt_w(input int max_losses);
    return $clog2(max_losses + 1);
  endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester-side handshake bundle for the SRAM arbiter (read port + write port).
// Requests are level, held until the matching one-cycle ack.
// master = requesters, slave = arbiter.
interface sram_arbiter_if;
  import sram_arbiter_pkg::*;

  logic               rd_req;
  logic [SRAM_AW-1:0] rd_addr;
  logic               rd_ack;
  logic [SRAM_DW-1:0] rd_data;
  logic               wr_req;
  logic [SRAM_AW-1:0] wr_addr;
  logic [SRAM_DW-1:0] wr_data;
  logic [1:0]         wr_be;
  logic               wr_ack;
  logic               busy;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
    input  rd_ack, rd_data, wr_ack, busy
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
    output rd_ack, rd_data, wr_ack, busy
  );

endinterface

// File: rtl/sram_timing_cnt.sv
// Loadable down-counter timing the RD and WR_PULSE phases.
// o_last is high while the count is zero, i.e. during the final cycle of a phase.
// Load has priority; the counter parks at zero.
module sram_timing_cnt
  import sram_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic [TIMER_W-1:0] i_load_val,
  output logic               o_last
);

  logic [TIMER_W-1:0] r_cnt;

  // Load the phase length, otherwise count down towards zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_last = (r_cnt == '0);

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates one async SRAM between a read requester and a write requester.
// Latency from sampling IDLE cycle: read ack at ACCESS_CYCLES+1, write ack at ACCESS_CYCLES+3.
// Reads win ties until a write has lost WR_STARVE_MAX times; requests are ignored while busy.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ACCESS_CYCLES = 2,
  parameter int WR_STARVE_MAX = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  sram_arbiter_if.slave      req_if,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic               sram_lb_n,
  output logic               sram_ub_n,
  output logic [SRAM_AW-1:0] sram_addr,
  inout  wire  [SRAM_DW-1:0] sram_data
);

  localparam int STARVE_W = starve_cnt_w(WR_STARVE_MAX);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(WR_STARVE_MAX);
  localparam logic [TIMER_W-1:0]  ACC_LOAD   = TIMER_W'(ACCESS_CYCLES - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [STARVE_W-1:0] r_starve_cnt;
  logic [STARVE_W-1:0] w_starve_nxt;
  logic                w_lat_rd;
  logic                w_lat_wr;
  logic                w_last;
  logic                w_timer_load;

  logic [SRAM_AW-1:0]  r_addr;
  logic [SRAM_DW-1:0]  r_wdata;
  logic [1:0]          r_be;
  logic [1:0]          w_be_nxt;
  logic [SRAM_DW-1:0]  r_rd_data;

  logic                r_ce_n, r_oe_n, r_we_n, r_lb_n, r_ub_n, r_drv_en;
  logic                w_ce_n, w_oe_n, w_we_n, w_lb_n, w_ub_n, w_drv_en;
  logic                r_rd_ack, r_wr_ack, r_busy;

  // The counter is reloaded in the state preceding each timed phase.
  assign w_timer_load = (r_state == ST_IDLE) || (r_state == ST_WR_SETUP);

  sram_timing_cnt u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_timer_load),
    .i_load_val (ACC_LOAD),
    .o_last     (w_last)
  );

  // FSM state and starvation counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
    end
  end

  // Next-state, grant decision and starvation accounting.
  always_comb begin
    w_state_nxt  = r_state;
    w_starve_nxt = r_starve_cnt;
    w_lat_rd     = 1'b0;
    w_lat_wr     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (req_if.rd_req && req_if.wr_req) begin
          if (r_starve_cnt == STARVE_MAX) begin
            w_state_nxt  = ST_WR_SETUP;
            w_lat_wr     = 1'b1;
            w_starve_nxt = '0;
          end else begin
            w_state_nxt = ST_RD;
            w_lat_rd    = 1'b1;
            if (r_starve_cnt != {STARVE_W{1'b1}}) begin
              w_starve_nxt = r_starve_cnt + 1'b1;
            end
          end
        end else if (req_if.rd_req) begin
          w_state_nxt = ST_RD;
          w_lat_rd    = 1'b1;
        end else if (req_if.wr_req) begin
          w_state_nxt  = ST_WR_SETUP;
          w_lat_wr     = 1'b1;
          w_starve_nxt = '0;
        end
      end
      ST_RD:       if (w_last) w_state_nxt = ST_TURN;
      ST_WR_SETUP: w_state_nxt = ST_WR_PULSE;
      ST_WR_PULSE: if (w_last) w_state_nxt = ST_WR_HOLD;
      ST_WR_HOLD:  w_state_nxt = ST_TURN;
      ST_TURN:     w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // Byte enables for the strobe decode: fresh from the port on the grant edge.
  assign w_be_nxt = w_lat_wr ? req_if.wr_be : r_be;

  // Pin values for the state being entered, so they can be registered.
  always_comb begin
    w_ce_n   = 1'b1;
    w_oe_n   = 1'b1;
    w_we_n   = 1'b1;
    w_lb_n   = 1'b1;
    w_ub_n   = 1'b1;
    w_drv_en = 1'b0;
    unique case (w_state_nxt)
      ST_RD: begin
        w_ce_n = 1'b0;
        w_oe_n = 1'b0;
        w_lb_n = 1'b0;
        w_ub_n = 1'b0;
      end
      ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD: begin
        w_ce_n   = 1'b0;
        w_we_n   = (w_state_nxt != ST_WR_PULSE);
        w_lb_n   = ~w_be_nxt[0];
        w_ub_n   = ~w_be_nxt[1];
        w_drv_en = 1'b1;
      end
      default: begin
        w_ce_n = 1'b1;
      end
    endcase
  end

  // Latch the granted request; inputs are not looked at again until the next IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
    end else if (w_lat_rd) begin
      r_addr <= req_if.rd_addr;
    end else if (w_lat_wr) begin
      r_addr  <= req_if.wr_addr;
      r_wdata <= req_if.wr_data;
      r_be    <= req_if.wr_be;
    end
  end

  // Registered strobes, drive enable, acks and busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ce_n   <= 1'b1;
      r_oe_n   <= 1'b1;
      r_we_n   <= 1'b1;
      r_lb_n   <= 1'b1;
      r_ub_n   <= 1'b1;
      r_drv_en <= 1'b0;
      r_rd_ack <= 1'b0;
      r_wr_ack <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_ce_n   <= w_ce_n;
      r_oe_n   <= w_oe_n;
      r_we_n   <= w_we_n;
      r_lb_n   <= w_lb_n;
      r_ub_n   <= w_ub_n;
      r_drv_en <= w_drv_en;
      r_rd_ack <= (r_state == ST_RD) && w_last;
      r_wr_ack <= (r_state == ST_WR_HOLD);
      r_busy   <= (w_state_nxt != ST_IDLE);
    end
  end

  // Capture read data on the final RD edge; held until the next read completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if ((r_state == ST_RD) && w_last) begin
      r_rd_data <= sram_data;
    end
  end

  assign sram_data = r_drv_en ? r_wdata : {SRAM_DW{1'bz}};

  assign sram_ce_n = r_ce_n;
  assign sram_oe_n = r_oe_n;
  assign sram_we_n = r_we_n;
  assign sram_lb_n = r_lb_n;
  assign sram_ub_n = r_ub_n;
  assign sram_addr = r_addr;

  assign req_if.rd_ack  = r_rd_ack;
  assign req_if.rd_data = r_rd_data;
  assign req_if.wr_ack  = r_wr_ack;
  assign req_if.busy    = r_busy;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural async SRAM model.
// ACCESS_CYCLES=2, WR_STARVE_MAX=8; expected values are hand-computed.
// Outputs sampled 1 time unit after each rising edge.
module tb_sram_arbiter;
  import sram_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tb_init;
  wire  [15:0] sram_data;
  logic        sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;
  logic [18:0] sram_addr;
  logic [15:0] mem [0:524287];
  logic [15:0] w_mem_rd;

  int errors = 0;
  int checks = 0;

  sram_arbiter_if bus();

  sram_arbiter #(.ACCESS_CYCLES(2), .WR_STARVE_MAX(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_if    (bus),
    .sram_ce_n (sram_ce_n),
    .sram_oe_n (sram_oe_n),
    .sram_we_n (sram_we_n),
    .sram_lb_n (sram_lb_n),
    .sram_ub_n (sram_ub_n),
    .sram_addr (sram_addr),
    .sram_data (sram_data)
  );

  always #5 clk = ~clk;

  // SRAM model: combinational read while CE and OE are low, write on WE rising edge.
  assign w_mem_rd  = mem[sram_addr];
  assign sram_data = (!sram_ce_n && !sram_oe_n) ? w_mem_rd : 16'hzzzz;

  always @(posedge sram_we_n or posedge tb_init) begin
    if (tb_init) begin
      mem[19'h00123] = 16'hA5C3;
      mem[19'h7FFFF] = 16'hBEEF;
      mem[19'h00200] = 16'h0000;
      mem[19'h00300] = 16'h0000;
      for (int i = 0; i < 16; i++) mem[19'(100 + i)] = 16'h1000 + 16'(i);
    end else if (!sram_ce_n) begin
      if (!sram_lb_n) mem[sram_addr][7:0]  = sram_data[7:0];
      if (!sram_ub_n) mem[sram_addr][15:8] = sram_data[15:8];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int          n_oe, n_ack, n_wack, ack_cyc, wack_cyc, end_cyc, ntx, k, rdbad;
  logic        drv_seen, overlap, lb_s, ub_s;
  logic [15:0] d_s, exp16;
  logic [7:0]  we_h, ce_h;
  logic [15:0] seq;

  initial begin
    tb_init = 1'b1;
    rst_n = 1'b0;
    bus.rd_req = 1'b0; bus.rd_addr = '0;
    bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_be = '0;
    #2 tb_init = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_ce_n",    32'(sram_ce_n), 32'd1);
    chk("rst_oe_n",    32'(sram_oe_n), 32'd1);
    chk("rst_we_n",    32'(sram_we_n), 32'd1);
    chk("rst_lanes",   32'({sram_lb_n, sram_ub_n}), 32'd3);
    chk("rst_addr",    32'(sram_addr), 32'd0);
    chk("rst_acks",    32'({bus.rd_ack, bus.wr_ack}), 32'd0);
    chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
    chk("rst_busy",    32'(bus.busy), 32'd0);
    chk("rst_drv",     32'(dut.r_drv_en), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single read at 0x00123
    bus.rd_req = 1'b1; bus.rd_addr = 19'h00123;
    n_oe = 0; n_ack = 0; ack_cyc = -1; drv_seen = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (!sram_oe_n) n_oe++;
      if (dut.r_drv_en) drv_seen = 1'b1;
      if (c == 1) chk("rd_busy", 32'(bus.busy), 32'd1);
      if (c == 1) bus.rd_addr = 19'h55555;
      if (bus.rd_ack) begin
        n_ack++;
        if (ack_cyc < 0) ack_cyc = c;
        bus.rd_req = 1'b0;
      end
    end
    chk("rd_oe_cycles", 32'(n_oe), 32'd2);
    chk("rd_ack_cycle", 32'(ack_cyc), 32'd3);
    chk("rd_ack_count", 32'(n_ack), 32'd1);
    chk("rd_data_held", 32'(bus.rd_data), 32'hA5C3);
    chk("rd_no_drive",  32'(drv_seen), 32'd0);
    chk("rd_idle_busy", 32'(bus.busy), 32'd0);

    // Single write, low byte only, inputs scrambled after latch
    bus.wr_req = 1'b1; bus.wr_addr = 19'h7FFFF; bus.wr_data = 16'h1234; bus.wr_be = 2'b01;
    we_h = '0; ce_h = '0; ack_cyc = -1; n_ack = 0;
    for (int c = 1; c <= 7; c++) begin
      tick();
      we_h[c] = sram_we_n;
      ce_h[c] = sram_ce_n;
      if (c == 1) begin bus.wr_data = 16'hFFFF; bus.wr_addr = 19'h0; bus.wr_be = 2'b11; end
      if (c == 2) begin lb_s = sram_lb_n; ub_s = sram_ub_n; d_s = sram_data; end
      if (bus.wr_ack) begin
        n_ack++;
        if (ack_cyc < 0) ack_cyc = c;
        bus.wr_req = 1'b0;
      end
    end
    chk("wr_we_seq",    32'(we_h[7:1]), 32'b1111001);
    chk("wr_ce_seq",    32'(ce_h[7:1]), 32'b1110000);
    chk("wr_lanes",     32'({lb_s, ub_s}), 32'b01);
    chk("wr_bus_data",  32'(d_s), 32'h1234);
    chk("wr_ack_cycle", 32'(ack_cyc), 32'd5);
    chk("wr_ack_count", 32'(n_ack), 32'd1);
    chk("wr_mem_byte",  32'(mem[19'h7FFFF]), 32'hBE34);

    // Simultaneous requests: read first, write after TURN
    bus.rd_req = 1'b1; bus.rd_addr = 19'h00123;
    bus.wr_req = 1'b1; bus.wr_addr = 19'h00200; bus.wr_data = 16'hCAFE; bus.wr_be = 2'b11;
    ack_cyc = -1; wack_cyc = -1; overlap = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (bus.rd_ack && bus.wr_ack) overlap = 1'b1;
      if (bus.rd_ack) begin if (ack_cyc < 0) ack_cyc = c; bus.rd_req = 1'b0; end
      if (bus.wr_ack) begin if (wack_cyc < 0) wack_cyc = c; bus.wr_req = 1'b0; end
    end
    chk("both_rd_ack", 32'(ack_cyc), 32'd3);
    chk("both_wr_ack", 32'(wack_cyc), 32'd9);
    chk("both_overlap", 32'(overlap), 32'd0);
    chk("both_wr_mem", 32'(mem[19'h00200]), 32'hCAFE);

    // Starvation: 8 reads, then the write, then reads resume
    k = 0; bus.rd_req = 1'b1; bus.rd_addr = 19'd100;
    bus.wr_req = 1'b1; bus.wr_addr = 19'h00300; bus.wr_data = 16'h5A5A; bus.wr_be = 2'b11;
    ntx = 0; seq = '0; rdbad = 0; end_cyc = -1; overlap = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      tick();
      if (bus.rd_ack && bus.wr_ack) overlap = 1'b1;
      if (bus.rd_ack && end_cyc < 0) begin
        exp16 = 16'h1000 + 16'(k);
        if (bus.rd_data !== exp16) rdbad++;
        ntx++; k++;
        bus.rd_addr = 19'(100 + k);
        if (ntx >= 11) begin bus.rd_req = 1'b0; end_cyc = c; end
      end
      if (bus.wr_ack) begin
        if (ntx < 16) seq[ntx] = 1'b1;
        ntx++;
        bus.wr_req = 1'b0;
      end
    end
    chk("starve_order",   32'(seq), 32'h0100);
    chk("starve_end",     32'(end_cyc), 32'd45);
    chk("starve_rd_data", 32'(rdbad), 32'd0);
    chk("starve_overlap", 32'(overlap), 32'd0);
    chk("starve_wr_mem",  32'(mem[19'h00300]), 32'h5A5A);

    // Back-to-back reads, address toggled after each ack
    bus.rd_req = 1'b1; bus.rd_addr = 19'h00123;
    n_ack = 0; ack_cyc = -1; end_cyc = -1; drv_seen = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (dut.r_drv_en) drv_seen = 1'b1;
      if (bus.rd_ack) begin
        n_ack++;
        if (ack_cyc < 0) ack_cyc = c;
        end_cyc = c;
        if (n_ack == 2) chk("b2b_rd2_data", 32'(bus.rd_data), 32'hBE34);
        bus.rd_addr = (n_ack == 1) ? 19'h7FFFF : 19'h00123;
        if (n_ack == 3) bus.rd_req = 1'b0;
      end
    end
    chk("b2b_count", 32'(n_ack), 32'd3);
    chk("b2b_first", 32'(ack_cyc), 32'd3);
    chk("b2b_last",  32'(end_cyc), 32'd11);
    chk("b2b_data",  32'(bus.rd_data), 32'hA5C3);
    chk("b2b_no_drive", 32'(drv_seen), 32'd0);

    // Write with both lanes disabled still runs full timing
    bus.wr_req = 1'b1; bus.wr_addr = 19'h00123; bus.wr_data = 16'h0000; bus.wr_be = 2'b00;
    ack_cyc = -1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 2) begin lb_s = sram_lb_n; ub_s = sram_ub_n; end
      if (bus.wr_ack) begin if (ack_cyc < 0) ack_cyc = c; bus.wr_req = 1'b0; end
    end
    chk("be0_lanes", 32'({lb_s, ub_s}), 32'b11);
    chk("be0_ack",   32'(ack_cyc), 32'd5);
    chk("be0_mem",   32'(mem[19'h00123]), 32'hA5C3);

    // Asynchronous reset in the middle of WR_PULSE
    bus.wr_req = 1'b1; bus.wr_addr = 19'h00400; bus.wr_data = 16'h7777; bus.wr_be = 2'b11;
    tick(); tick();
    chk("mid_pulse_we", 32'(sram_we_n), 32'd0);
    rst_n = 1'b0;
    bus.wr_req = 1'b0;
    #1;
    chk("arst_we_n",  32'(sram_we_n), 32'd1);
    chk("arst_ce_n",  32'(sram_ce_n), 32'd1);
    chk("arst_busy",  32'(bus.busy), 32'd0);
    chk("arst_drv",   32'(dut.r_drv_en), 32'd0);
    chk("arst_ack",   32'(bus.wr_ack), 32'd0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("post_rst_busy",  32'(bus.busy), 32'd0);
    chk("post_rst_state", 32'(dut.r_state), 32'(ST_IDLE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Arbitrates the single external async SRAM between two requesters.
  - Read requester: the VGA pixel-fetch path, clocked on the pixel clock domain's source.
  - Write requester: the UART frame loader.
- Generates all SRAM control strobes from flops, with fixed setup/access/hold timing.
- Instantiated inside the UART/SRAM display path, replacing ad-hoc SRAM driving. Owns the sram_* pins.

Parameters:
- ACCESS_CYCLES, 2: clock cycles of OE-low for reads and WE-low for writes; legal range 1..15.
- WR_STARVE_MAX, 8: consecutive arbitration losses after which a pending write is forced through; legal range 1..255.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- rd_req  in  1  read request; held until rd_ack
- rd_addr  in  19  read word address
- rd_ack  out  1  one-cycle pulse; rd_data valid in the same cycle
- rd_data  out  16  read data; holds its value until the next read completes
- wr_req  in  1  write request; held until wr_ack
- wr_addr  in  19  write word address
- wr_data  in  16  write data
- wr_be  in  2  byte enables; [0]=low byte, [1]=high byte, active-high
- wr_ack  out  1  one-cycle pulse; write is complete at the SRAM
- busy  out  1  high in any state other than IDLE
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  SRAM strobes, active-low
- sram_lb_n, sram_ub_n  out  1 each  SRAM byte lanes, active-low
- sram_addr  out  19  SRAM address
- sram_data  inout  16  SRAM data bus; driven only in write states, otherwise high-Z

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - ce_n/oe_n/we_n/lb_n/ub_n = 1.
  - sram_addr = 0; sram_data high-Z.
  - rd_ack = wr_ack = 0; rd_data = 0; busy = 0.
  - starve_cnt = 0; FSM = IDLE.
- All sram_* outputs and the data-drive enable come from registers. No combinational path from req to pins.
- FSM states: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, TURN.
- IDLE: samples requests on each clock edge.
  - Only rd_req: go to RD, latch rd_addr.
  - Only wr_req: go to WR_SETUP, latch wr_addr/wr_data/wr_be.
  - Both requests:
    - If starve_cnt == WR_STARVE_MAX: write wins, starve_cnt = 0.
    - Otherwise: read wins, starve_cnt += 1 (saturating).
  - Any granted write clears starve_cnt.
- RD: lasts ACCESS_CYCLES cycles. ce_n=0, oe_n=0, lb_n=ub_n=0, bus high-Z. On the final RD edge, rd_data <= sram_data. Then go to TURN with rd_ack=1.
- WR_SETUP: 1 cycle. ce_n=0, we_n=1, addr and data driven, lb_n=~wr_be[0], ub_n=~wr_be[1].
- WR_PULSE: ACCESS_CYCLES cycles. Same as WR_SETUP but we_n=0.
- WR_HOLD: 1 cycle. we_n=1; addr, data and byte lanes still driven. Then go to TURN with wr_ack=1.
- TURN: 1 cycle.
  - All strobes deasserted, bus high-Z.
  - Requests are ignored.
  - The ack pulse is high during this cycle.
  - Return to IDLE.
- Requester rule: after seeing ack, the requester drops req, or presents a new address, in the next cycle. That next cycle is the first IDLE sample.
- Latency, counted from the IDLE edge that samples the request (cycle 0):
  - Read: rd_ack in cycle ACCESS_CYCLES+1.
  - Write: wr_ack in cycle ACCESS_CYCLES+3.
- Request dropped before ack: the transaction still completes and the ack still pulses. Inputs are not re-sampled after latch.
- wr_be = 2'b00: full write cycle timing is still executed with both lanes disabled, and wr_ack still pulses.
- Address/data inputs may change freely after the latch edge.

Decomposition:
- Shared package holds:
  - FSM state encoding.
  - SRAM_AW=19 and SRAM_DW=16.
  - A function for the starve counter width: clog2(WR_STARVE_MAX+1).
- One natural sub-module: sram_timing_cnt. It is a loadable down-counter; it signals the last cycle of the RD and WR_PULSE phases.
- Tri-state buffer stays in this module: a single assign on sram_data with a registered enable.

Test Plan:
- Reset values: assert rst_n=0 during WR_PULSE → in the same cycle we_n=1, ce_n=1, sram_data=Z, busy=0, and the FSM is IDLE after release.
- Single read, ACCESS_CYCLES=2, SRAM model returns 16'hA5C3 at addr 19'h00123 → oe_n low for exactly 2 cycles, rd_ack in cycle 3, rd_data=16'hA5C3 held afterwards.
- Single write, addr 19'h7FFFF, data 16'h1234, be=2'b01 → strobe sequence SETUP/PULSE×2/HOLD, lb_n=0, ub_n=1, wr_ack in cycle 5; model byte at 7FFFF low = 8'h34, high byte unchanged.
- Simultaneous rd_req and wr_req in the same IDLE cycle → read serviced first, write starts on the IDLE after TURN, acks never overlap.
- Starvation: rd_req held continuously with new addresses, wr_req held, WR_STARVE_MAX=8 → 8 reads complete, then the write is granted as the 9th transaction, then reads resume.
- Back-to-back reads, requester toggling address the cycle after each rd_ack → one read per ACCESS_CYCLES+2 cycles, no duplicate transaction, sram_data never driven.
